// File: rtl/ifu_ctrl_if.sv
// Instruction-memory port of the fetch sequencer: request/grant followed by a
// separate response beat.
interface ifu_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifu_ctrl.sv
// ifu_ctrl: multi-cycle fetch/execute sequencer for the single-cycle RV core.
// Optional fetch timeout is built in when IFU_TIMEOUT_EN is defined.
module ifu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    ifu_ctrl_if.master  imem,
    output logic [31:0] inst,
    output logic        exec_en,
    output logic        pc_we,
    input  logic        halt_req,
    output logic        halted,
    output logic [31:0] instret,
    output logic        fetch_err
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic        exec_q;
    logic        halted_q;
    logic [31:0] inst_q;
    logic [31:0] instret_q;
    logic        timeout_hit;

    // The timeout counter is 8 bits wide.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ifu_ctrl: TIMEOUT must be in 1..255");
    end

`ifdef IFU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic       fetch_err_q;

    // A response that completes in the last allowed cycle beats the timeout.
    assign timeout_hit = (cnt_q == TIMEOUT_LAST) &&
                         ((state_q == S_REQ) ||
                          (state_q == S_WAIT && !imem.imem_rvalid));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            if (state_q == S_REQ || state_q == S_WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end
            if (timeout_hit) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // NOTE: every register here is written with <= so all of them sample the
    // pre-edge state; a blocking = would leak new values into later lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            exec_q    <= 1'b0;
            halted_q  <= 1'b0;
            inst_q    <= NOP;
            instret_q <= '0;
        end else begin
            req_q  <= 1'b0;
            exec_q <= 1'b0;
            if (timeout_hit) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                    S_REQ: begin
                        if (imem.imem_gnt) begin
                            state_q <= S_WAIT;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem.imem_rvalid) begin
                            inst_q  <= imem.imem_rdata;
                            state_q <= S_EXEC;
                            exec_q  <= 1'b1;
                        end
                    end
                    S_EXEC: begin
                        instret_q <= instret_q + 32'd1;
                        if (halt_req) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                    S_HALT: begin
                        state_q <= S_HALT;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // The PC register updates on the EXEC edge, so the address must follow pc
    // directly to present the new value in the first REQ cycle.
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req_q;

    assign inst    = inst_q;
    assign exec_en = exec_q;
    assign pc_we   = exec_q;
    assign halted  = halted_q;
    assign instret = instret_q;
endmodule

// File: tb/tb_ifu_ctrl.sv
// Self-checking bench for ifu_ctrl: randomized memory latencies and noise
// against a transaction-level model of fetch, commit, halt and reset.
module tb_ifu_ctrl;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_BASE = 32'h0000_1000;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exec_en;
    logic        pc_we;
    logic        halt_req;
    logic        halted;
    logic [31:0] instret;
    logic        fetch_err;

    ifu_ctrl_if bus ();

    ifu_ctrl #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .imem      (bus.master),
        .inst      (inst),
        .exec_en   (exec_en),
        .pc_we     (pc_we),
        .halt_req  (halt_req),
        .halted    (halted),
        .instret   (instret),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the core's PC register.
    always @(posedge clk) begin
        if (!rst) pc <= PC_BASE;
        else if (pc_we) pc <= pc + 32'd4;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned retired_m;
    logic [31:0] inst_m;
    bit          halted_m;
    bit          err_m;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        halt_req        = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_cycle(input string tag, input bit req, input bit ex);
        check({tag, ".req"}, 32'(bus.imem_req), 32'(req));
        if (req) check({tag, ".addr"}, bus.imem_addr, PC_BASE + 32'(4 * retired_m));
        check({tag, ".exec_en"}, 32'(exec_en), 32'(ex));
        check({tag, ".pc_we"}, 32'(pc_we), 32'(ex));
        check({tag, ".inst"}, inst, inst_m);
        check({tag, ".instret"}, instret, 32'(retired_m));
        check({tag, ".halted"}, 32'(halted), 32'(halted_m));
        check({tag, ".fetch_err"}, 32'(fetch_err), 32'(err_m));
    endtask

    // Hold reset for n edges, release it and step through the IDLE cycle.
    task automatic apply_reset(input int n);
        rst = 1'b0;
        retired_m = 0;
        inst_m    = NOP;
        halted_m  = 1'b0;
        err_m     = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_idle();
            step();
            expect_cycle("reset", 1'b0, 1'b0);
        end
        rst = 1'b1;
        drive_idle();
        step();
    endtask

    // One fetch starting in the first REQ cycle. abort: 0 none, 1 reset in
    // WAIT, 2 reset in EXEC.
    task automatic fetch(input logic [31:0] data, input int gnt_dly, input int rv_dly,
                         input bit halt, input bit spur, input int abort);
        expect_cycle("req", 1'b1, 1'b0);
        for (int i = 0; i < gnt_dly; i++) begin
            drive_idle();
            if (spur) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = JUNK;
            end
            step();
            expect_cycle("req_hold", 1'b1, 1'b0);
        end
        drive_idle();
        bus.imem_gnt = 1'b1;
        step();
        expect_cycle("wait", 1'b0, 1'b0);
        if (abort == 1) begin
            apply_reset(2);
            return;
        end
        for (int j = 0; j < rv_dly; j++) begin
            drive_idle();
            step();
            expect_cycle("wait_hold", 1'b0, 1'b0);
        end
        drive_idle();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        inst_m = data;
        expect_cycle("exec", 1'b0, 1'b1);
        if (abort == 2) begin
            apply_reset(1);
            return;
        end
        drive_idle();
        halt_req = halt;
        if (spur) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = JUNK;
        end
        step();
        retired_m++;
        if (halt) begin
            halted_m = 1'b1;
            expect_cycle("halt", 1'b0, 1'b0);
        end else begin
            expect_cycle("next", 1'b1, 1'b0);
        end
    endtask

    // Fetch whose response never arrives; optionally the grant never comes either.
    task automatic stall_run(input bit grant);
        drive_idle();
        bus.imem_gnt = grant;
        step();
`ifdef IFU_TIMEOUT_EN
        for (int k = 1; k <= 12; k++) begin
            if (k == 8) begin
                halted_m = 1'b1;
                err_m    = 1'b1;
            end
            expect_cycle("timeout", !grant && k < 8, 1'b0);
            drive_idle();
            step();
        end
`else
        for (int k = 1; k <= 1000; k++) begin
            expect_cycle("stall", !grant, 1'b0);
            drive_idle();
            step();
        end
`endif
        apply_reset(2);
    endtask

    initial begin
        drive_idle();
        halt_req = 1'b0;
        @(negedge clk);
        apply_reset(3);

        // Single fetch with minimum latency.
        fetch(32'h0010_0093, 0, 0, 1'b0, 1'b0, 0);

        // Stream with fixed long latencies.
        for (int i = 0; i < 10; i++) fetch($urandom, 3, 2, 1'b0, 1'b0, 0);
        check("stream.instret", instret, 32'd11);

        // Halt on the 5th instruction, with halt noise and spurious responses.
        apply_reset(2);
        for (int i = 0; i < 5; i++)
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2), i == 4, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            drive_idle();
            bus.imem_rvalid = 1'($urandom_range(0, 1));
            bus.imem_gnt    = 1'($urandom_range(0, 1));
            step();
            expect_cycle("halted", 1'b0, 1'b0);
        end
        check("halt.instret", instret, 32'd5);

        // Reset mid-WAIT and during EXEC.
        apply_reset(2);
        fetch($urandom, 1, 1, 1'b0, 1'b0, 0);
        fetch($urandom, 2, 1, 1'b0, 1'b0, 1);
        fetch($urandom, 0, 0, 1'b0, 1'b0, 0);
        fetch($urandom, 1, 0, 1'b0, 1'b0, 2);

        // Randomized traffic.
        for (int i = 0; i < 40; i++)
            fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0,
                  1'($urandom_range(0, 1)), 0);

        stall_run(1'b1);
        stall_run(1'b0);
        fetch($urandom, 0, 0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
